// File: rtl/rx_arb_pkg.sv
// rx_arb_pkg: shared types and defaults for the RX port arbiter
package rx_arb_pkg;
  typedef enum logic [1:0] {IDLE, FWD, FLUSH} arb_state_t;
  localparam int N_PORTS_DEF = 4;
  localparam int MAX_FRAME_WORDS_DEF = 380;
  localparam int TDATA_WIDTH_DEF = 32;
  typedef logic [$clog2(N_PORTS_DEF)-1:0] port_idx_t;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick starting after last_grant
module rr_priority_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic          any_req,
  output logic [IW-1:0] pick_idx
);
  always_comb begin
    any_req = |req;
    pick_idx = last_grant;
    // walk farthest-first so the closest requester after last_grant wins
    for (int i = N; i >= 1; i--)
      if (req[(int'(last_grant) + i) % N]) pick_idx = IW'((int'(last_grant) + i) % N);
  end
endmodule

// File: rtl/rx_port_arbiter.sv
// rx_port_arbiter: frame-granular round-robin share of one packet_parser between RX ports
module rx_port_arbiter import rx_arb_pkg::*; #(
  parameter int N_PORTS = N_PORTS_DEF,
  parameter int C_s_axis_rxd_TDATA_WIDTH = TDATA_WIDTH_DEF,
  parameter int MAX_FRAME_WORDS = MAX_FRAME_WORDS_DEF,
  localparam int W = C_s_axis_rxd_TDATA_WIDTH,
  localparam int IW = $clog2(N_PORTS),
  localparam int CW = $clog2(MAX_FRAME_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PORTS-1:0]   i_rxd_tvalid,
  input  logic [N_PORTS-1:0]   i_rxd_tlast,
  input  logic [N_PORTS*W-1:0] i_rx_tdata,
  output logic [N_PORTS-1:0]   o_rxd_tready,
  output logic                 o_pp_tvalid,
  output logic                 o_pp_tlast,
  output logic [W-1:0]         o_pp_tdata,
  input  logic                 i_pp_tready,
  output logic [IW-1:0]        o_grant,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_frame_trunc
);
  arb_state_t state, state_nx;
  logic [IW-1:0] grant, last_grant, pick_idx;
  logic [CW-1:0] cnt;
  logic any_req, acc, p_valid, p_last, at_max;
  rr_priority_pick #(.N(N_PORTS)) u_pick (
    .req(i_rxd_tvalid),
    .last_grant(last_grant),
    .any_req(any_req),
    .pick_idx(pick_idx)
  );
  assign p_valid = i_rxd_tvalid[grant];
  assign p_last = i_rxd_tlast[grant];
  assign at_max = cnt == CW'(MAX_FRAME_WORDS - 1);
  assign o_grant = grant;
  always_comb begin
    state_nx = state;
    o_rxd_tready = '0;
    o_pp_tvalid = 1'b0;
    o_pp_tlast = 1'b0;
    o_pp_tdata = '0;
    o_frame_done = 1'b0;
    o_frame_trunc = 1'b0;
    acc = 1'b0;
    case (state)
      IDLE: state_nx = any_req ? FWD : IDLE;
      FWD: begin
        o_rxd_tready[grant] = i_pp_tready;
        o_pp_tvalid = p_valid;
        o_pp_tlast = p_last | at_max;
        o_pp_tdata = i_rx_tdata[int'(grant)*W +: W];
        acc = p_valid & i_pp_tready;
        o_frame_done = acc & p_last;
        o_frame_trunc = acc & at_max & ~p_last;
        state_nx = o_frame_done ? IDLE : o_frame_trunc ? FLUSH : FWD;
      end
      FLUSH: begin
        // the parser already saw a forced tlast; drain the rest of the frame
        o_rxd_tready[grant] = 1'b1;
        state_nx = (p_valid & p_last) ? IDLE : FLUSH;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IW'(N_PORTS - 1);
      cnt <= '0;
      o_busy <= 1'b0;
    end else begin
      state <= state_nx;
      o_busy <= state_nx != IDLE;
      if (state == IDLE && any_req) begin
        grant <= pick_idx;
        last_grant <= pick_idx;
        cnt <= '0;
      end else if (acc) cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_rx_port_arbiter.sv
// tb_rx_port_arbiter: frame-level model and directed scenarios for rx_port_arbiter
module tb_rx_port_arbiter;
  import rx_arb_pkg::*;
  localparam int N = 4, W = 32, MAX = 380;
  typedef struct {int port; int beats; bit trunc; int first; int last;} frame_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] tv = '0, tl = '0, rdy;
  logic [N*W-1:0] td = '0;
  logic pp_v, pp_l, pp_r = 1'b1, busy, done, trunc;
  logic [W-1:0] pp_d;
  port_idx_t grant;
  frame_t flog[$];
  int src_q[N][$];
  int pos[N], fid[N];
  int m_port = -1, m_sent = 0, m_last = N - 1, m_greg = 0, m_first = 0, cyc = 0;
  bit m_flush = 1'b0, rst_req = 1'b1;
  bit rdy_q[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  rx_port_arbiter #(.N_PORTS(N), .C_s_axis_rxd_TDATA_WIDTH(W), .MAX_FRAME_WORDS(MAX)) dut (
    .clk(clk), .rst(rst), .i_rxd_tvalid(tv), .i_rxd_tlast(tl), .i_rx_tdata(td),
    .o_rxd_tready(rdy), .o_pp_tvalid(pp_v), .o_pp_tlast(pp_l), .o_pp_tdata(pp_d),
    .i_pp_tready(pp_r), .o_grant(grant), .o_busy(busy), .o_frame_done(done), .o_frame_trunc(trunc)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask
  // one cycle: drive sources, compare every output against the frame model, then advance
  task automatic step();
    logic [N-1:0] sv, sl, e_rdy;
    logic [W-1:0] e_d;
    bit fwd, e_v, e_l, e_acc, e_done, e_trunc;
    int g, pick;
    @(negedge clk);
    rst = rst_req;
    pp_r = rdy_q.size() > 0 ? rdy_q.pop_front() : 1'b1;
    for (int p = 0; p < N; p++) begin
      sv[p] = src_q[p].size() > 0;
      sl[p] = sv[p] && pos[p] == src_q[p][0] - 1;
      td[p*W +: W] = sv[p] ? {8'(p), 8'(fid[p]), 16'(pos[p])} : '0;
    end
    tv = sv;
    tl = sl;
    #1;
    g = m_port < 0 ? 0 : m_port;
    fwd = m_port >= 0 && !m_flush;
    e_rdy = '0;
    if (m_port >= 0) e_rdy[g] = m_flush | pp_r;
    e_v = fwd && sv[g];
    e_l = fwd && (sl[g] || m_sent == MAX - 1);
    e_d = fwd ? {8'(g), 8'(fid[g]), 16'(pos[g])} : '0;
    e_acc = e_v && pp_r;
    e_done = e_acc && sl[g];
    e_trunc = e_acc && !sl[g] && m_sent == MAX - 1;
    chk("tready", 64'(rdy), 64'(e_rdy));
    chk("pp_tvalid", 64'(pp_v), 64'(e_v));
    chk("pp_tlast", 64'(pp_l), 64'(e_l));
    chk("pp_tdata", 64'(pp_d), 64'(e_d));
    chk("grant", 64'(grant), 64'(m_greg));
    chk("busy", 64'(busy), 64'(m_port >= 0));
    chk("frame_done", 64'(done), 64'(e_done));
    chk("frame_trunc", 64'(trunc), 64'(e_trunc));
    for (int p = 0; p < N; p++)
      if (sv[p] && e_rdy[p]) begin
        pos[p]++;
        if (pos[p] == src_q[p][0]) begin
          void'(src_q[p].pop_front());
          pos[p] = 0;
          fid[p]++;
        end
      end
    if (rst_req) begin
      m_port = -1; m_last = N - 1; m_greg = 0; m_flush = 0; m_sent = 0;
    end else if (m_port < 0) begin
      pick = -1;
      for (int k = N; k >= 1; k--) if (sv[(m_last + k) % N]) pick = (m_last + k) % N;
      if (pick >= 0) begin
        m_port = pick; m_last = pick; m_greg = pick; m_sent = 0; m_flush = 0;
      end
    end else if (!m_flush) begin
      if (e_acc) begin
        if (m_sent == 0) m_first = cyc;
        m_sent++;
        if (e_done) begin
          flog.push_back('{g, m_sent, 1'b0, m_first, cyc});
          m_port = -1;
        end else if (e_trunc) begin
          flog.push_back('{g, m_sent, 1'b1, m_first, cyc});
          m_flush = 1;
        end
      end
    end else if (sv[g] && sl[g]) begin
      m_port = -1;
      m_flush = 0;
    end
    cyc++;
  endtask
  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (flog.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("frames_seen", 64'(flog.size()), 64'(n));
  endtask
  task automatic pulse_rst();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    for (int p = 0; p < N; p++) begin
      src_q[p].delete();
      pos[p] = 0;
    end
  endtask
  task automatic run_until_sent(input int port, input int beats);
    int k = 0;
    while (!(m_port == port && m_sent == beats) && k < 50) begin
      step();
      k++;
    end
    chk("reach_beat", 64'(m_sent), 64'(beats));
  endtask
  initial begin
    @(posedge clk);
    step();
    step();
    rst_req = 1'b0;
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_ready", 64'(rdy), 64'd0);
    // port 2, 16 beats
    src_q[2].push_back(16);
    wait_frames(1, 40);
    step();
    chk("t1_port", 64'(flog[0].port), 64'd2);
    chk("t1_beats", 64'(flog[0].beats), 64'd16);
    chk("t1_trunc", 64'(flog[0].trunc), 64'd0);
    chk("t1_contig", 64'(flog[0].last - flog[0].first), 64'd15);
    chk("t1_idle", 64'(busy), 64'd0);
    // ports 0,1,3 together after reset: order 0,1,3,0 with one bubble
    pulse_rst();
    src_q[0].push_back(4);
    src_q[0].push_back(4);
    src_q[1].push_back(4);
    src_q[3].push_back(4);
    wait_frames(5, 60);
    chk("t2_p0", 64'(flog[1].port), 64'd0);
    chk("t2_p1", 64'(flog[2].port), 64'd1);
    chk("t2_p2", 64'(flog[3].port), 64'd3);
    chk("t2_p3", 64'(flog[4].port), 64'd0);
    for (int k = 1; k <= 4; k++) chk("t2_contig", 64'(flog[k].last - flog[k].first), 64'd3);
    for (int k = 1; k <= 3; k++) chk("t2_bubble", 64'(flog[k+1].first - flog[k].last), 64'd2);
    // toggling parser ready during a 6-beat frame
    step();
    for (int k = 0; k < 30; k++) rdy_q.push_back(k[0] == 1'b0);
    src_q[0].push_back(6);
    wait_frames(6, 40);
    rdy_q.delete();
    chk("t3_port", 64'(flog[5].port), 64'd0);
    chk("t3_beats", 64'(flog[5].beats), 64'd6);
    // 400-beat frame truncated at 380, remainder flushed
    step();
    src_q[1].push_back(400);
    wait_frames(7, 420);
    chk("t4_port", 64'(flog[6].port), 64'd1);
    chk("t4_beats", 64'(flog[6].beats), 64'd380);
    chk("t4_trunc", 64'(flog[6].trunc), 64'd1);
    for (int k = 0; k < 40 && (src_q[1].size() > 0 || m_port >= 0); k++) step();
    step();
    chk("t4_flushed", 64'(src_q[1].size()), 64'd0);
    chk("t4_no_done", 64'(flog.size()), 64'd7);
    chk("t4_idle", 64'(busy), 64'd0);
    // exactly 380 beats ends normally
    src_q[2].push_back(380);
    wait_frames(8, 420);
    chk("t5_beats", 64'(flog[7].beats), 64'd380);
    chk("t5_trunc", 64'(flog[7].trunc), 64'd0);
    step();
    // reset on beat 5 of a port 3 frame, then port 3 again
    src_q[3].push_back(10);
    run_until_sent(3, 4);
    pulse_rst();
    src_q[3].push_back(2);
    step();
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_ready", 64'(rdy), 64'd0);
    chk("t6_rst_grant", 64'(grant), 64'd0);
    wait_frames(9, 20);
    chk("t6_port", 64'(flog[8].port), 64'd3);
    chk("t6_beats", 64'(flog[8].beats), 64'd2);
    // reset mid port-1 frame restores port 0 priority: 1 beats 2
    step();
    src_q[1].push_back(10);
    run_until_sent(1, 3);
    pulse_rst();
    src_q[1].push_back(2);
    src_q[2].push_back(2);
    wait_frames(11, 30);
    chk("t7_first", 64'(flog[9].port), 64'd1);
    chk("t7_second", 64'(flog[10].port), 64'd2);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
